conv_1st_out_collect: RTL and testbench

CONV_1ST_OUT_COLLECT -- requirements
Module: conv_1st_out_collect

---
 rtl/conv_1st_out_collect.sv | 123 ++++++++++++
 tb/tb_conv_1st_out_collect.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/conv_1st_out_collect.sv
// Collects first-layer convolution result groups, quantises each lane (ReLU, shift, saturate),
// buffers groups in a FIFO and serialises them one lane per handshake.
//
// state | meaning
// IDLE  | FIFO empty, no beat offered
// SEND  | head entry offered lane by lane; popped on handshake of the last lane
module conv_1st_out_collect #(
  parameter int LANES = 6,
  parameter int IN_W  = 20,
  parameter int OUT_W = 8,
  parameter int SHIFT = 6,
  parameter int DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    valid_i,
  input  logic [4:0]              weight_num_i,
  input  logic [LANES*IN_W-1:0]   data_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [OUT_W-1:0]        out_data_o,
  output logic [4:0]              out_ch_o,
  output logic                    out_half_o,
  output logic [2:0]              out_lane_o,
  output logic                    out_last_o,
  output logic                    ovf_o,
  output logic [$clog2(DEPTH):0]  level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [IN_W-1:0] SAT = {{(IN_W-OUT_W){1'b0}}, {OUT_W{1'b1}}};
  localparam logic [2:0] LAST_LANE = 3'(LANES-1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       level_q, level_d;
  logic [2:0]        lane_q, lane_d;
  logic              half_q, ovf_q;
  logic              full, hs, pop, push;

  logic [OUT_W-1:0]  q_lane [LANES];
  logic [OUT_W-1:0]  mem_d [DEPTH][LANES];
  logic [4:0]        mem_ch [DEPTH];
  logic              mem_half [DEPTH];

  for (genvar g = 0; g < LANES; g++) begin : g_quant
    logic signed [IN_W-1:0] raw;
    logic [IN_W-1:0]        sh;
    assign raw       = data_i[g*IN_W +: IN_W];
    assign sh        = raw[IN_W-1] ? '0 : ($unsigned(raw) >> SHIFT);
    assign q_lane[g] = (sh > SAT) ? {OUT_W{1'b1}} : sh[OUT_W-1:0];
  end

  assign full = (level_q == (AW+1)'(DEPTH));
  assign hs   = out_valid_o && out_ready_i;
  assign pop  = hs && (lane_q == LAST_LANE);
  // A full FIFO still accepts a group when the head leaves on the same edge.
  assign push = valid_i && (!full || pop);

  always_comb begin
    level_d = level_q;
    lane_d  = lane_q;
    state_d = state_q;
    if (push && !pop)
      level_d = level_q + (AW+1)'(1);
    else if (pop && !push)
      level_d = level_q - (AW+1)'(1);
    if (hs)
      lane_d = (lane_q == LAST_LANE) ? 3'd0 : lane_q + 3'd1;
    // Next state follows next occupancy so a push into an empty FIFO is offered one cycle later.
    case (state_q)
      IDLE:    if (level_d != '0) state_d = SEND;
      SEND:    if (level_d == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      level_q <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      lane_q  <= '0;
      half_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      lane_q  <= lane_d;
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
        half_q <= ~half_q;
      end
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      if (valid_i && !push)
        ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      for (int i = 0; i < LANES; i++)
        mem_d[wr_ptr][i] <= q_lane[i];
      mem_ch[wr_ptr]   <= weight_num_i;
      mem_half[wr_ptr] <= half_q;
    end
  end

  // Storage is not reset, so beat fields are forced to zero whenever no beat is offered.
  assign out_valid_o = (state_q == SEND);
  assign out_data_o  = out_valid_o ? mem_d[rd_ptr][lane_q] : '0;
  assign out_ch_o    = out_valid_o ? mem_ch[rd_ptr] : 5'd0;
  assign out_half_o  = out_valid_o && mem_half[rd_ptr];
  assign out_lane_o  = lane_q;
  assign out_last_o  = out_valid_o && (out_ch_o == 5'd31) && out_half_o && (lane_q == LAST_LANE);
  assign ovf_o       = ovf_q;
  assign level_o     = level_q;

endmodule

// File: tb/tb_conv_1st_out_collect.sv
// Bench for conv_1st_out_collect: directed and random steps checked against a queue-based
// model of the collector (quantise, buffer, emit lane by lane).
module tb_conv_1st_out_collect;
  localparam int LANES = 6;
  localparam int IN_W  = 20;
  localparam int OUT_W = 8;
  localparam int SHIFT = 6;
  localparam int DEPTH = 8;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  valid_i;
  logic [4:0]            weight_num_i;
  logic [LANES*IN_W-1:0] data_i;
  logic                  out_valid_o;
  logic                  out_ready_i;
  logic [OUT_W-1:0]      out_data_o;
  logic [4:0]            out_ch_o;
  logic                  out_half_o;
  logic [2:0]            out_lane_o;
  logic                  out_last_o;
  logic                  ovf_o;
  logic [3:0]            level_o;

  always #5 clk = ~clk;

  conv_1st_out_collect #(.LANES(LANES), .IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .weight_num_i(weight_num_i), .data_i(data_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
    .out_ch_o(out_ch_o), .out_half_o(out_half_o), .out_lane_o(out_lane_o),
    .out_last_o(out_last_o), .ovf_o(ovf_o), .level_o(level_o)
  );

  typedef struct packed {
    logic [LANES-1:0][OUT_W-1:0] d;
    logic [4:0]                  ch;
    logic                        half;
  } ent_t;

  ent_t mq[$];
  int   m_lane;
  logic m_half, m_ovf;
  int   n_vec, n_err, beats, last_cnt, last_at;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  function automatic logic [OUT_W-1:0] quant(input logic signed [IN_W-1:0] x);
    int v;
    v = int'(x);
    if (v < 0) return '0;
    v = v / (1 << SHIFT);
    if (v > (1 << OUT_W) - 1) v = (1 << OUT_W) - 1;
    return OUT_W'(v);
  endfunction

  function automatic logic [LANES*IN_W-1:0] rand_group();
    logic [LANES*IN_W-1:0] g;
    logic [IN_W-1:0]       x;
    g = '0;
    for (int i = 0; i < LANES; i++) begin
      case ($urandom_range(0, 3))
        0:       x = IN_W'($urandom_range(0, 20000));
        1:       x = IN_W'(-int'($urandom_range(1, 500)));
        2:       x = IN_W'($urandom_range(0, 300));
        default: x = IN_W'($urandom);
      endcase
      g[i*IN_W +: IN_W] = x;
    end
    return g;
  endfunction

  task automatic step(input logic v, input logic [4:0] w, input logic [LANES*IN_W-1:0] d, input logic rdy);
    bit   ev, pop, obs_last;
    ent_t e;
    valid_i      = v;
    weight_num_i = w;
    data_i       = d;
    out_ready_i  = rdy;
    @(negedge clk);
    ev = (mq.size() != 0);
    obs_last = out_last_o;
    chk("valid", {31'd0, out_valid_o}, {31'd0, ev});
    if (ev) begin
      chk("data", {24'd0, out_data_o}, {24'd0, mq[0].d[m_lane]});
      chk("ch",   {27'd0, out_ch_o},   {27'd0, mq[0].ch});
      chk("half", {31'd0, out_half_o}, {31'd0, mq[0].half});
      chk("lane", {29'd0, out_lane_o}, 32'(m_lane));
      chk("last", {31'd0, out_last_o},
          {31'd0, (mq[0].ch == 5'd31) && mq[0].half && (m_lane == LANES-1)});
    end
    chk("level", {28'd0, level_o}, 32'(mq.size()));
    chk("ovf",   {31'd0, ovf_o},   {31'd0, m_ovf});
    @(posedge clk);
    if (!rst_n) begin
      mq.delete();
      m_lane = 0;
      m_half = 1'b0;
      m_ovf  = 1'b0;
    end else begin
      pop = ev && rdy && (m_lane == LANES-1);
      if (ev && rdy) begin
        beats++;
        if (obs_last) begin
          last_cnt++;
          last_at = beats;
        end
        m_lane = (m_lane == LANES-1) ? 0 : m_lane + 1;
      end
      if (pop) mq.delete(0);
      if (v) begin
        if (mq.size() < DEPTH) begin
          for (int i = 0; i < LANES; i++) e.d[i] = quant(d[i*IN_W +: IN_W]);
          e.ch   = w;
          e.half = m_half;
          mq.push_back(e);
          m_half = ~m_half;
        end else begin
          m_ovf = 1'b1;
        end
      end
    end
    #1;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b0, 5'd0, '0, rdy);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle(2, 1'b1);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [LANES*IN_W-1:0] g38;
    n_vec = 0; n_err = 0; beats = 0; last_cnt = 0; last_at = 0;
    m_lane = 0; m_half = 1'b0; m_ovf = 1'b0;
    rst_n = 1'b0; valid_i = 1'b0; weight_num_i = '0; data_i = '0; out_ready_i = 1'b1;
    @(posedge clk);
    #1;
    do_reset();

    chk("rst_valid", {31'd0, out_valid_o}, 32'd0);
    chk("rst_lane",  {29'd0, out_lane_o},  32'd0);
    chk("rst_data",  {24'd0, out_data_o},  32'd0);
    chk("rst_ch",    {27'd0, out_ch_o},    32'd0);
    chk("rst_half",  {31'd0, out_half_o},  32'd0);
    chk("rst_last",  {31'd0, out_last_o},  32'd0);
    chk("rst_level", {28'd0, level_o},     32'd0);
    chk("rst_ovf",   {31'd0, ovf_o},       32'd0);

    // single group with boundary lane values
    g38 = {20'sd20000, 20'sd16383, 20'sd64, 20'sd63, 20'sd0, -20'sd5};
    step(1'b1, 5'd3, g38, 1'b1);
    idle(8, 1'b1);

    // backpressure on lane 2
    step(1'b1, 5'd7, rand_group(), 1'b1);
    idle(2, 1'b1);
    idle(4, 1'b0);
    idle(6, 1'b1);

    // overflow: nine groups into a stalled FIFO
    for (int k = 0; k < 9; k++) step(1'b1, 5'($urandom_range(0, 31)), rand_group(), 1'b0);
    idle(1, 1'b0);
    chk("ovf_level", {28'd0, level_o}, 32'd8);
    chk("ovf_flag",  {31'd0, ovf_o},   32'd1);
    idle(52, 1'b1);

    // full FIFO with push on the lane-5 handshake
    do_reset();
    for (int k = 0; k < 8; k++) step(1'b1, 5'(k), rand_group(), 1'b0);
    idle(5, 1'b1);
    step(1'b1, 5'd20, rand_group(), 1'b1);
    chk("simul_level", {28'd0, level_o}, 32'd8);
    chk("simul_ovf",   {31'd0, ovf_o},   32'd0);
    idle(56, 1'b1);

    // full frame of 64 groups
    do_reset();
    beats = 0; last_cnt = 0; last_at = 0;
    for (int k = 0; k < 64; k++) begin
      step(1'b1, 5'(k / 2), rand_group(), 1'b1);
      idle(5, 1'b1);
    end
    idle(4, 1'b1);
    chk("frame_beats",   32'(beats),    32'd384);
    chk("frame_lastcnt", 32'(last_cnt), 32'd1);
    chk("frame_lastat",  32'(last_at),  32'd384);

    // reset during lane 3
    step(1'b1, 5'd9, rand_group(), 1'b1);
    idle(3, 1'b1);
    rst_n = 1'b0;
    idle(1, 1'b1);
    rst_n = 1'b1;
    chk("midrst_valid", {31'd0, out_valid_o}, 32'd0);
    chk("midrst_level", {28'd0, level_o},     32'd0);
    chk("midrst_ovf",   {31'd0, ovf_o},       32'd0);
    idle(3, 1'b1);
    step(1'b1, 5'd12, rand_group(), 1'b1);
    chk("midrst_half", {31'd0, out_half_o}, 32'd0);
    idle(7, 1'b1);

    // random traffic
    do_reset();
    for (int k = 0; k < 500; k++)
      step(1'($urandom_range(0, 3) == 0), 5'($urandom_range(0, 31)), rand_group(),
           1'($urandom_range(0, 3) != 0));
    idle(60, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
